// File: rtl/pose_tracker.sv
// Grid pose tracker: infers robot position and heading on a square grid
// from the motor-driver pattern issued by the drive controller. Forward
// drive held for a full cell time advances one cell along the heading; spin
// drive held for a full turn time rotates the heading by 90 degrees.
module pose_tracker #(
  parameter int         STEP_TICKS = 50,
  parameter int         TURN_TICKS = 100,
  parameter int         START_X    = 0,
  parameter int         START_Y    = 0,
  parameter logic [1:0] START_ORI  = 2'b00,
  parameter int         GRID_MAX   = 39
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in1,
  input  logic        in2,
  input  logic        in3,
  input  logic        in4,
  input  logic        in5,
  input  logic        in6,
  input  logic        in7,
  input  logic        in8,
  input  logic        arrived,
  output logic [32:0] sX,
  output logic [32:0] sY,
  output logic [1:0]  ori,
  output logic        moving,
  output logic        step_done,
  output logic        turn_done,
  output logic        bound_hit
);

  localparam int TICK_MAX = (STEP_TICKS > TURN_TICKS) ? STEP_TICKS : TURN_TICKS;
  localparam int CNT_W    = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;

  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_TICKS - 1);
  localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_TICKS - 1);

  localparam logic [32:0] COORD_MAX = 33'(GRID_MAX);
  localparam logic [32:0] INIT_X    = 33'(START_X);
  localparam logic [32:0] INIT_Y    = 33'(START_Y);

  localparam logic [1:0] ORI_N = 2'b00;
  localparam logic [1:0] ORI_E = 2'b01;
  localparam logic [1:0] ORI_W = 2'b10;
  localparam logic [1:0] ORI_S = 2'b11;

  localparam logic [7:0] PATTERN_FWD    = 8'b1010_1010;
  localparam logic [7:0] PATTERN_SPIN_L = 8'b1010_0101;
  localparam logic [7:0] PATTERN_SPIN_R = 8'b0101_1010;

  typedef enum logic [1:0] {
    PAT_BRAKE,
    PAT_FWD,
    PAT_SPIN_L,
    PAT_SPIN_R
  } pat_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FWD,
    ST_TURN_L,
    ST_TURN_R,
    ST_TURN_WAIT,
    ST_HALT
  } state_e;

  // Move one cell along an axis, saturating at the grid edges.
  // Returns {blocked, next_coordinate}; a blocked move keeps the input value.
  function automatic logic [33:0] sat_step(input logic [32:0] c, input logic up);
    logic [33:0] res;
    if (up) begin
      if (c >= COORD_MAX) res = {1'b1, c};
      else                res = {1'b0, c + 33'd1};
    end else begin
      if (c == 33'd0)     res = {1'b1, c};
      else                res = {1'b0, c - 33'd1};
    end
    return res;
  endfunction

  // Clockwise quarter turn: N -> E -> S -> W -> N.
  function automatic logic [1:0] rot_right(input logic [1:0] o);
    logic [1:0] r;
    case (o)
      ORI_N:   r = ORI_E;
      ORI_E:   r = ORI_S;
      ORI_S:   r = ORI_W;
      default: r = ORI_N;
    endcase
    return r;
  endfunction

  // Counter-clockwise quarter turn: N -> W -> S -> E -> N.
  function automatic logic [1:0] rot_left(input logic [1:0] o);
    logic [1:0] r;
    case (o)
      ORI_N:   r = ORI_W;
      ORI_W:   r = ORI_S;
      ORI_S:   r = ORI_E;
      default: r = ORI_N;
    endcase
    return r;
  endfunction

  // State to enter from a resting state for a given drive pattern.
  function automatic state_e entry_state(input pat_e p);
    state_e s;
    case (p)
      PAT_FWD:    s = ST_FWD;
      PAT_SPIN_L: s = ST_TURN_L;
      PAT_SPIN_R: s = ST_TURN_R;
      default:    s = ST_IDLE;
    endcase
    return s;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [32:0]      sx_q, sx_d, sy_q, sy_d;
  logic [1:0]       ori_q, ori_d;
  logic             step_q, step_d;
  logic             turn_q, turn_d;
  logic             bound_q, bound_d;

  logic [7:0]       pattern;
  pat_e             pat;
  logic             axis_vert;
  logic             axis_up;
  logic [33:0]      axis_res;

  assign pattern = {in1, in2, in3, in4, in5, in6, in7, in8};

  // Decode the driver pattern; anything unrecognised is treated as brake.
  always_comb begin
    pat = PAT_BRAKE;
    case (pattern)
      PATTERN_FWD:    pat = PAT_FWD;
      PATTERN_SPIN_L: pat = PAT_SPIN_L;
      PATTERN_SPIN_R: pat = PAT_SPIN_R;
      default:        pat = PAT_BRAKE;
    endcase
  end

  // Candidate cell move along the current heading, with edge saturation.
  always_comb begin
    axis_vert = (ori_q == ORI_N) || (ori_q == ORI_S);
    axis_up   = (ori_q == ORI_N) || (ori_q == ORI_E);
    axis_res  = sat_step(axis_vert ? sy_q : sx_q, axis_up);
  end

  // Next-state, tick counter, pose and pulse logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    ori_d   = ori_q;
    step_d  = 1'b0;
    turn_d  = 1'b0;
    bound_d = 1'b0;

    if (arrived) begin
      // Destination reached: freeze everything, drop any completion due now.
      state_d = ST_HALT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = entry_state(pat);
          cnt_d   = '0;
        end

        ST_FWD: begin
          if (pat != PAT_FWD) begin
            state_d = entry_state(pat);
            cnt_d   = '0;
          end else if (cnt_q == STEP_LAST) begin
            cnt_d = '0;
            if (axis_res[33]) begin
              bound_d = 1'b1;
            end else begin
              step_d = 1'b1;
              if (axis_vert) sy_d = axis_res[32:0];
              else           sx_d = axis_res[32:0];
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        ST_TURN_L: begin
          if (pat != PAT_SPIN_L) begin
            state_d = entry_state(pat);
            cnt_d   = '0;
          end else if (cnt_q == TURN_LAST) begin
            cnt_d   = '0;
            ori_d   = rot_left(ori_q);
            turn_d  = 1'b1;
            state_d = ST_TURN_WAIT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        ST_TURN_R: begin
          if (pat != PAT_SPIN_R) begin
            state_d = entry_state(pat);
            cnt_d   = '0;
          end else if (cnt_q == TURN_LAST) begin
            cnt_d   = '0;
            ori_d   = rot_right(ori_q);
            turn_d  = 1'b1;
            state_d = ST_TURN_WAIT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        ST_TURN_WAIT: begin
          // A held spin pattern must be released before another turn counts.
          if ((pat != PAT_SPIN_L) && (pat != PAT_SPIN_R)) begin
            state_d = entry_state(pat);
            cnt_d   = '0;
          end
        end

        ST_HALT: begin
          cnt_d = '0;
        end

        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Control state and tick counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered pose and completion pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sx_q    <= INIT_X;
      sy_q    <= INIT_Y;
      ori_q   <= START_ORI;
      step_q  <= 1'b0;
      turn_q  <= 1'b0;
      bound_q <= 1'b0;
    end else begin
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      ori_q   <= ori_d;
      step_q  <= step_d;
      turn_q  <= turn_d;
      bound_q <= bound_d;
    end
  end

  assign sX        = sx_q;
  assign sY        = sy_q;
  assign ori       = ori_q;
  assign moving    = (state_q == ST_FWD) || (state_q == ST_TURN_L) || (state_q == ST_TURN_R);
  assign step_done = step_q;
  assign turn_done = turn_q;
  assign bound_hit = bound_q;

endmodule

// File: tb/tb_pose_tracker.sv
// Scoreboard bench for pose_tracker: each expected completion pulse (kind and
// resulting pose) is queued when its stimulus is driven and checked when the
// DUT raises the pulse. A second instance starts in a corner facing west.
module tb_pose_tracker;

  localparam logic [7:0] P_FWD    = 8'b1010_1010;
  localparam logic [7:0] P_SPIN_L = 8'b1010_0101;
  localparam logic [7:0] P_SPIN_R = 8'b0101_1010;
  localparam logic [7:0] P_BRAKE  = 8'b0000_0000;
  localparam logic [7:0] P_BAD    = 8'b1111_1111;

  localparam logic [2:0] K_STEP  = 3'b100;
  localparam logic [2:0] K_TURN  = 3'b010;
  localparam logic [2:0] K_BOUND = 3'b001;

  typedef struct {
    logic [2:0]  kind;
    logic [32:0] sx;
    logic [32:0] sy;
    logic [1:0]  o;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] pat, pat_b;
  logic arrived, arrived_b;

  logic [32:0] sX, sY, sX_b, sY_b;
  logic [1:0]  ori, ori_b;
  logic moving, step_done, turn_done, bound_hit;
  logic moving_b, step_done_b, turn_done_b, bound_hit_b;

  int n_chk = 0;
  int n_err = 0;
  int nb_bound = 0;
  int nb_step = 0;
  ev_t sb[$];

  always #5 clk = ~clk;

  pose_tracker #(
    .STEP_TICKS(4), .TURN_TICKS(3), .START_X(5), .START_Y(5),
    .START_ORI(2'b00), .GRID_MAX(39)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in1(pat[7]), .in2(pat[6]), .in3(pat[5]), .in4(pat[4]),
    .in5(pat[3]), .in6(pat[2]), .in7(pat[1]), .in8(pat[0]),
    .arrived(arrived),
    .sX(sX), .sY(sY), .ori(ori), .moving(moving),
    .step_done(step_done), .turn_done(turn_done), .bound_hit(bound_hit)
  );

  pose_tracker #(
    .STEP_TICKS(4), .TURN_TICKS(3), .START_X(0), .START_Y(0),
    .START_ORI(2'b10), .GRID_MAX(39)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in1(pat_b[7]), .in2(pat_b[6]), .in3(pat_b[5]), .in4(pat_b[4]),
    .in5(pat_b[3]), .in6(pat_b[2]), .in7(pat_b[1]), .in8(pat_b[0]),
    .arrived(arrived_b),
    .sX(sX_b), .sY(sY_b), .ori(ori_b), .moving(moving_b),
    .step_done(step_done_b), .turn_done(turn_done_b), .bound_hit(bound_hit_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_ev(input logic [2:0] kind, input int x, input int y, input logic [1:0] o);
    ev_t e;
    e.kind = kind;
    e.sx   = 33'(x);
    e.sy   = 33'(y);
    e.o    = o;
    sb.push_back(e);
  endtask

  // Hold a pattern for n rising edges; returns just after the last edge.
  task automatic run(input logic [7:0] p, input int n, input bit on_b = 1'b0);
    if (on_b) pat_b = p;
    else      pat   = p;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Let the negedge monitors consume the latest cycle before checking.
  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  // Main instance: every completion pulse must match the next queued event.
  always @(negedge clk) begin
    logic [2:0] kind;
    ev_t e;
    kind = {step_done, turn_done, bound_hit};
    if (kind != 3'b000) begin
      chk("pulse_onehot", 64'($countones(kind) <= 1), 64'd1);
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 64'(kind), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", 64'(kind), 64'(e.kind));
        chk("pulse_sx", 64'(sX), 64'(e.sx));
        chk("pulse_sy", 64'(sY), 64'(e.sy));
        chk("pulse_ori", 64'(ori), 64'(e.o));
      end
    end
  end

  // Corner instance: tally its pulses.
  always @(negedge clk) begin
    if (bound_hit_b) nb_bound++;
    if (step_done_b) nb_step++;
  end

  initial begin
    rst_n     = 1'b0;
    pat       = P_BRAKE;
    pat_b     = P_BRAKE;
    arrived   = 1'b0;
    arrived_b = 1'b0;

    // Reset values.
    @(negedge clk);
    chk("rst_sx", 64'(sX), 64'd5);
    chk("rst_sy", 64'(sY), 64'd5);
    chk("rst_ori", 64'(ori), 64'd0);
    chk("rst_moving", 64'(moving), 64'd0);
    chk("rst_pulses", 64'({step_done, turn_done, bound_hit}), 64'd0);
    chk("rst_b_sx", 64'(sX_b), 64'd0);
    chk("rst_b_ori", 64'(ori_b), 64'd2);
    #2;
    rst_n = 1'b1;

    // Corner instance facing west: the step is blocked at x=0.
    run(P_FWD, 5, 1'b1);
    pat_b = P_BRAKE;
    settle();
    chk("edge_bound_cnt", 64'(nb_bound), 64'd1);
    chk("edge_step_cnt", 64'(nb_step), 64'd0);
    chk("edge_sx", 64'(sX_b), 64'd0);
    chk("edge_sy", 64'(sY_b), 64'd0);

    // Forward north: three cells in twelve forward cycles.
    push_ev(K_STEP, 5, 6, 2'b00);
    push_ev(K_STEP, 5, 7, 2'b00);
    push_ev(K_STEP, 5, 8, 2'b00);
    run(P_FWD, 13);
    settle();
    chk("fwd_moving", 64'(moving), 64'd1);
    chk("fwd_sx", 64'(sX), 64'd5);
    chk("fwd_sy", 64'(sY), 64'd8);
    chk("fwd_sb_empty", 64'(sb.size()), 64'd0);
    run(P_BRAKE, 1);

    // Sustained spin right gives exactly one turn, then a step east.
    push_ev(K_TURN, 5, 8, 2'b01);
    run(P_SPIN_R, 10);
    push_ev(K_STEP, 6, 8, 2'b01);
    run(P_FWD, 5);
    settle();
    chk("spinr_ori", 64'(ori), 64'd1);
    chk("spinr_sx", 64'(sX), 64'd6);
    chk("spinr_sb_empty", 64'(sb.size()), 64'd0);

    // Invalid pattern acts as brake.
    run(P_BAD, 1);
    settle();
    chk("invalid_idle", 64'(moving), 64'd0);

    // Partial forward run is discarded; left turn then step west.
    do_reset();
    run(P_FWD, 3);
    push_ev(K_TURN, 5, 5, 2'b10);
    run(P_SPIN_L, 4);
    push_ev(K_STEP, 4, 5, 2'b10);
    run(P_FWD, 5);
    settle();
    chk("partial_ori", 64'(ori), 64'd2);
    chk("partial_sx", 64'(sX), 64'd4);
    chk("partial_sy", 64'(sY), 64'd5);
    chk("partial_sb_empty", 64'(sb.size()), 64'd0);

    // Arrival on the terminal cycle suppresses the step and halts for good.
    do_reset();
    run(P_FWD, 4);
    arrived = 1'b1;
    run(P_FWD, 1);
    arrived = 1'b0;
    run(P_FWD, 8);
    settle();
    chk("halt_sy", 64'(sY), 64'd5);
    chk("halt_moving", 64'(moving), 64'd0);
    chk("halt_sb_empty", 64'(sb.size()), 64'd0);
    do_reset();
    push_ev(K_STEP, 5, 6, 2'b00);
    run(P_FWD, 5);
    settle();
    chk("post_halt_sy", 64'(sY), 64'd6);

    // Asynchronous reset mid-turn.
    run(P_BRAKE, 1);
    run(P_SPIN_R, 2);
    chk("pre_arst_moving", 64'(moving), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_sx", 64'(sX), 64'd5);
    chk("arst_sy", 64'(sY), 64'd5);
    chk("arst_ori", 64'(ori), 64'd0);
    chk("arst_moving", 64'(moving), 64'd0);
    chk("arst_pulses", 64'({step_done, turn_done, bound_hit}), 64'd0);
    #2;
    rst_n = 1'b1;
    run(P_BRAKE, 2);
    settle();
    chk("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pose_tracker.md
POSE_TRACKER -- requirements
Module: pose_tracker

Interface
REQ-001 Parameter STEP_TICKS, default 50: clk cycles of forward drive per grid cell.
REQ-002 Parameter TURN_TICKS, default 100: clk cycles of spin drive per 90-degree turn.
REQ-003 Parameter START_X, default 0; START_Y, default 0; START_ORI, default 2'b00: pose loaded at reset.
REQ-004 Parameter GRID_MAX, default 39: highest legal coordinate on either axis.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 in1..in8  input  1 each  motor-driver pattern issued by the drive controller.
REQ-008 arrived  input  1  drive controller reports destination reached.
REQ-009 sX, sY  output  33 each  current grid coordinates, registered.
REQ-010 ori  output  2  current heading, registered: 00 north, 01 east, 10 west, 11 south.
REQ-011 moving  output  1  high while in FWD, TURN_L or TURN_R.
REQ-012 step_done  output  1  one-cycle pulse on each completed cell move.
REQ-013 turn_done  output  1  one-cycle pulse on each completed 90-degree turn.
REQ-014 bound_hit  output  1  one-cycle pulse when a step is blocked at a grid edge.

Function
REQ-015 Pattern decode, in1..in8 MSB-first: 10101010 = FWD, 10100101 = SPIN_L, 01011010 = SPIN_R, 00000000 = BRAKE; any other value = INVALID, treated as BRAKE.
REQ-016 States: IDLE, FWD, TURN_L, TURN_R, TURN_WAIT, HALT; one tick counter, wide enough for max(STEP_TICKS, TURN_TICKS).
REQ-017 IDLE: FWD pattern -> FWD; SPIN_L -> TURN_L; SPIN_R -> TURN_R; counter cleared on every entry.
REQ-018 FWD: counter increments each cycle; at STEP_TICKS-1 the counter clears and the heading axis updates in the same cycle: north sY+1, south sY-1, east sX+1, west sX-1; step_done pulses; state stays FWD.
REQ-019 Step saturation: a step that would take a coordinate below 0 or above GRID_MAX leaves the pose unchanged, pulses bound_hit instead of step_done, and clears the counter.
REQ-020 TURN_R: at TURN_TICKS-1 ori updates 00->01, 01->11, 11->10, 10->00; turn_done pulses; next state TURN_WAIT.
REQ-021 TURN_L: at TURN_TICKS-1 ori updates 00->10, 10->11, 11->01, 01->00; turn_done pulses; next state TURN_WAIT.
REQ-022 TURN_WAIT: holds until the pattern is not a spin; then follows the IDLE transitions in that same cycle. A sustained spin pattern yields exactly one turn.
REQ-023 Pattern change mid-FWD or mid-turn: partial progress is discarded, pose and ori unchanged, counter cleared; next state chosen per REQ-017 in that cycle.
REQ-024 BRAKE or INVALID in FWD, TURN_L or TURN_R -> IDLE.
REQ-025 arrived high in any state -> HALT next cycle, overriding all other transitions; any completion due in that same cycle is suppressed. HALT holds pose, all pulses low, and exits only by reset.
REQ-026 Latency: pose or ori change is visible on outputs one cycle after the terminal-count edge, together with its pulse. At most one of step_done, turn_done and bound_hit is high in any cycle.
REQ-027 sX and sY are unsigned and always within 0..GRID_MAX; the upper bits stay zero.

Reset
REQ-028 rst_n low, at any time including mid-move: sX=START_X, sY=START_Y, ori=START_ORI, state IDLE, counter 0, moving, step_done, turn_done and bound_hit all 0.
REQ-029 After rst_n deasserts, the first transition is evaluated on the next rising clk edge.

Verification (bench parameters STEP_TICKS=4, TURN_TICKS=3, START 5,5, ori 00)
REQ-030 Hold FWD for 12 cycles -> sY steps 6, 7, 8, with one step_done per step; sX stays 5; moving=1.
REQ-031 Hold SPIN_R for 10 cycles, then FWD for 4 cycles -> ori=01 after cycle 3; only one turn_done; then sX=6.
REQ-032 START 0,0, ori 10, FWD for 4 cycles -> sX=0, bound_hit pulses once, step_done stays 0.
REQ-033 FWD for 2 cycles, SPIN_L for 3 cycles, FWD for 4 cycles -> no step from the partial run; ori=10; then sX=4.
REQ-034 Assert arrived on the 4th FWD cycle -> no step_done, sY=5, HALT; a following FWD pattern is ignored until rst_n is pulsed.
REQ-035 Pull rst_n low on the 2nd SPIN_R cycle -> all outputs return to reset values immediately, with no clock edge needed.
